rotating_banner_mux: RTL
========================

// Module: rotating_banner_mux
// PURPOSE
//  Parametrised rotating LED banner for multiplexed 7-segment displays.
//  - Holds a writable MSG_LEN-entry message of hex/blank symbols.
//  - Scrolls the message across N_DIG time-multiplexed digits, left or right,
//    either continuously (prescaled tick) or one step per pulse.
//  - Next-generation banner for the pong board display path: adds a runtime
//    message load, single-step mode, blanking and a configurable digit count.
// PARAMETERS
//  N_DIG    4           number of physical digits; 1 <= N_DIG <= MSG_LEN
//  MSG_LEN  10          message length in symbols; >= 2
//  ROT_DIV  50_000_000  clock cycles per rotation step while en=1; >= 2
//  REF_DIV  50_000      clock cycles each digit stays selected; >= 1
//  AW       $clog2(MSG_LEN)  address/pointer width (derived, localparam)
// PORTS
//  clock    in   1      system clock, rising edge
//  reset    in   1      asynchronous, active-high reset
//  en       in   1      1 = continuous rotation on prescaled tick
//  dir      in   1      0 = scroll left (ptr+1), 1 = scroll right (ptr-1)
//  step     in   1      single-cycle pulse: one rotation step, only when en=0
//  wr_en    in   1      message write strobe
//  wr_addr  in   AW     message entry to write
//  wr_data  in   5      [4]=blank, [3:0]=hex symbol
//  segment  out  7      active-low segments, bit0=a .. bit6=g
//  anode    out  N_DIG  active-low digit enables, anode[N_DIG-1] = leftmost
//  pos      out  AW     current rotation pointer (ptr)
// BEHAVIOUR
//  - Reset (async, immediate): ptr=0, rot_cnt=0, ref_cnt=0, sel=0,
//    anode=all 1s, segment=7'h7F, msg[i]={1'b0, i mod 16}.
//  - Rotation prescaler: en=1 -> rot_cnt counts 0..ROT_DIV-1, tick when
//    rot_cnt==ROT_DIV-1, then wraps to 0. en=0 -> rot_cnt cleared to 0.
//  - Advance event = tick (en=1) or step (en=0); step ignored while en=1.
//    dir sampled on the advance edge.
//    dir=0: ptr = (ptr==MSG_LEN-1) ? 0 : ptr+1
//    dir=1: ptr = (ptr==0) ? MSG_LEN-1 : ptr-1
//  - Mapping: digit k (k=0 leftmost) shows msg[(ptr+k) mod MSG_LEN]; the
//    modulo is computed without a divider (compare-and-subtract).
//  - Refresh: ref_cnt counts 0..REF_DIV-1; on wrap, sel = (sel==N_DIG-1) ? 0 : sel+1.
//  - Outputs registered: each edge loads anode = ~(1 << (N_DIG-1-sel)) and
//    segment = decode(msg[(ptr+sel) mod MSG_LEN]); anode and segment change
//    on the same edge, 1-cycle latency from sel/ptr/msg.
//  - Decode (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000
//    4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//    A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110;
//    blank bit set -> 7'h7F.
//  - Write: wr_en=1 and wr_addr<MSG_LEN -> msg[wr_addr]=wr_data at the edge;
//    wr_addr>=MSG_LEN ignored. Write and advance in the same cycle both apply.
//  - Reset mid-operation aborts everything; message returns to default.
// TESTING  (bench params: N_DIG=4, MSG_LEN=10, ROT_DIV=4, REF_DIV=2)
//  1 Reset held -> anode=4'hF, segment=7'h7F, pos=0; after release anode steps
//    0111,1011,1101,1110 every 2 cycles, segment=7'h40,7'h79,7'h24,7'h30.
//  2 en=1 dir=0 -> pos advances every 4 cycles 0..9 then 0; at pos=8 digits
//    show 8,9,0,1 (wrap-around).
//  3 en=1 dir=1 from pos=0 -> pos=9 then 8; at pos=9 digits show 9,0,1,2.
//  4 en=0, three 1-cycle step pulses -> pos=3; step with en=1 ignored, pos
//    changes only on ticks.
//  5 Write addr 2 data 5'h10 -> digit showing msg[2] = 7'h7F; addr 0 data
//    5'h0A -> 7'b0001000; addr 10 write -> no change.
//  6 Reset asserted at pos=6 between edges -> pos=0, anode=4'hF immediately,
//    default message restored after release.

Source files
------------

// File: rtl/rotating_banner_mux.sv
// Rotating hex banner on N_DIG multiplexed active-low 7-segment digits, with writable message.
// anode/segment are registered with 1-cycle latency from sel/ptr/msg; there is no backpressure.
module rotating_banner_mux #(
  parameter int N_DIG   = 4,
  parameter int MSG_LEN = 10,
  parameter int ROT_DIV = 50_000_000,
  parameter int REF_DIV = 50_000,
  localparam int AW     = $clog2(MSG_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             step,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [4:0]       wr_data,
  output logic [6:0]       segment,
  output logic [N_DIG-1:0] anode,
  output logic [AW-1:0]    pos
);

  localparam int RW   = $clog2(ROT_DIV);
  localparam int REFW = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int SW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [4:0]       msg [MSG_LEN];
  logic [AW-1:0]    ptr;
  logic [RW-1:0]    rot_cnt;
  logic [REFW-1:0]  ref_cnt;
  logic [SW-1:0]    sel;

  logic             tick;
  logic             advance;
  logic             ref_wrap;
  logic [AW:0]      sum;
  logic [AW-1:0]    idx;
  logic [SW-1:0]    sh;
  logic [N_DIG-1:0] anode_nxt;
  logic             wr_ok;

  function automatic logic [6:0] decode(input logic [4:0] s);
    logic [6:0] seg;
    if (s[4]) begin
      seg = 7'h7F;
    end else begin
      case (s[3:0])
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
    return seg;
  endfunction

  assign tick     = en && (rot_cnt == RW'(ROT_DIV - 1));
  assign advance  = tick || (!en && step);
  assign ref_wrap = (ref_cnt == REFW'(REF_DIV - 1));
  assign wr_ok    = wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

  // sel < N_DIG <= MSG_LEN, so ptr+sel < 2*MSG_LEN and one conditional subtract is a full modulo.
  always_comb begin
    sum = {1'b0, ptr} + (AW + 1)'(sel);
    idx = AW'(sum);
    if (sum >= (AW + 1)'(MSG_LEN)) begin
      idx = AW'(sum - (AW + 1)'(MSG_LEN));
    end
    sh        = SW'(N_DIG - 1) - sel;
    anode_nxt = ~(N_DIG'(1) << sh);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      rot_cnt <= '0;
      ref_cnt <= '0;
      sel     <= '0;
      anode   <= '1;
      segment <= 7'h7F;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= {1'b0, 4'(i)};
      end
    end else begin
      if (!en || tick) rot_cnt <= '0;
      else             rot_cnt <= rot_cnt + 1'b1;

      if (advance) begin
        if (!dir) ptr <= (ptr == AW'(MSG_LEN - 1)) ? '0 : ptr + 1'b1;
        else      ptr <= (ptr == '0) ? AW'(MSG_LEN - 1) : ptr - 1'b1;
      end

      if (ref_wrap) begin
        ref_cnt <= '0;
        sel     <= (sel == SW'(N_DIG - 1)) ? '0 : sel + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      anode   <= anode_nxt;
      segment <= decode(msg[idx]);

      if (wr_ok) msg[wr_addr] <= wr_data;
    end
  end

  assign pos = ptr;

endmodule
